delivery_velocity_sensor: RTL and testbench

// - Ultrasonic front end feeding the delivery game control unit: on each get_velocity pulse,

---
 rtl/delivery_game_pkg.sv | 34 +++
 rtl/delivery_sync2.sv | 24 ++
 rtl/delivery_velocity_sensor.sv | 191 +++++++++++++++++++
 tb/tb_delivery_velocity_sensor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/delivery_game_pkg.sv
// Shared definitions for the delivery game blocks: FSM encodings, default timing
// constants and the velocity saturation helper.
package delivery_game_pkg;

    localparam int CLK_FREQ       = 50_000_000;
    localparam int TRIGGER_CYCLES = 500;
    localparam int CYCLES_PER_CM  = 2915;
    localparam int ECHO_TIMEOUT   = 1_500_000;
    localparam int MAX_CM         = 400;
    localparam int DIST_W         = 9;
    localparam int VEL_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIGGER   = 3'd1,
        ST_WAIT_ECHO = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_COMPUTE   = 3'd4,
        ST_DONE      = 3'd5,
        ST_FAULT     = 3'd6
    } state_e;

    // Clamp a signed distance difference into the signed velocity range.
    function automatic logic [VEL_W-1:0] sat_vel(input logic signed [15:0] d);
        if (d > 16'sd127) begin
            return 8'h7f;
        end else if (d < -16'sd128) begin
            return 8'h80;
        end else begin
            return d[VEL_W-1:0];
        end
    endfunction

endpackage

// File: rtl/delivery_sync2.sv
// Two-flop synchronizer for asynchronous game inputs (sensor echo, buttons).
module delivery_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/delivery_velocity_sensor.sv
// HC-SR04 front end: one measurement per get_velocity pulse, echo width to cm,
// velocity as the distance change since the previous valid sample.
module delivery_velocity_sensor #(
    parameter int TRIGGER_CYCLES = delivery_game_pkg::TRIGGER_CYCLES,
    parameter int CYCLES_PER_CM  = delivery_game_pkg::CYCLES_PER_CM,
    parameter int ECHO_TIMEOUT   = delivery_game_pkg::ECHO_TIMEOUT,
    parameter int MAX_CM         = delivery_game_pkg::MAX_CM,
    parameter int DIST_W         = delivery_game_pkg::DIST_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              get_velocity,
    input  logic              clear,
    input  logic              echo,
    output logic              trigger,
    output logic              busy,
    output logic [DIST_W-1:0] distance,
    output logic [7:0]        velocity,
    output logic              velocity_ready,
    output logic              sensor_fault,
    output logic [2:0]        state_dbg
);
    import delivery_game_pkg::*;

    localparam int CNT_W = $clog2(ECHO_TIMEOUT + 1);
    localparam int SUB_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [DIST_W-1:0] CM_MAX    = DIST_W'(MAX_CM);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SUB_W-1:0]    sub_q, sub_d;
    logic [DIST_W-1:0]   cm_q, cm_d;
    logic [DIST_W-1:0]   distance_q, distance_d;
    logic [DIST_W-1:0]   prev_q, prev_d;
    logic [7:0]          velocity_q, velocity_d;
    logic                hist_q, hist_d;
    logic                fault_q, fault_d;
    logic                trigger_q, trigger_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                echo_s, echo_prev_q;
    logic                echo_rise, echo_fall;
    logic signed [DIST_W:0] diff;

    delivery_sync2 u_echo_sync (
        .clk   (clock),
        .rst_n (reset_n),
        .d     (echo),
        .q     (echo_s)
    );

    assign echo_rise = echo_s & ~echo_prev_q;
    assign echo_fall = ~echo_s & echo_prev_q;
    assign diff      = $signed({1'b0, prev_q}) - $signed({1'b0, cm_q});

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sub_d      = sub_q;
        cm_d       = cm_q;
        distance_d = distance_q;
        prev_d     = prev_q;
        velocity_d = velocity_q;
        hist_d     = hist_q;
        fault_d    = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (get_velocity) begin
                    state_d = ST_TRIGGER;
                    cnt_d   = '0;
                end
            end
            ST_TRIGGER: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = ST_WAIT_ECHO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_ECHO: begin
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = '0;
                    sub_d   = '0;
                    cm_d    = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                // Every MEASURE cycle, including the one that sees the fall, is one echo clock.
                if (sub_q == SUB_LAST) begin
                    sub_d = '0;
                    if (cm_q != CM_MAX) cm_d = cm_q + 1'b1;
                end else begin
                    sub_d = sub_q + 1'b1;
                end
                if (echo_fall) begin
                    state_d = ST_COMPUTE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COMPUTE: begin
                distance_d = cm_q;
                velocity_d = hist_q ? sat_vel(16'(diff)) : 8'h00;
                prev_d     = cm_q;
                hist_d     = 1'b1;
                fault_d    = 1'b0;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort keeps the measurement history; only the in-flight work is dropped.
        if (clear) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            sub_d      = '0;
            cm_d       = '0;
            distance_d = distance_q;
            prev_d     = prev_q;
            velocity_d = velocity_q;
            hist_d     = hist_q;
            fault_d    = fault_q;
        end

        trigger_d = (state_d == ST_TRIGGER);
        busy_d    = (state_d != ST_IDLE);
        ready_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sub_q       <= '0;
            cm_q        <= '0;
            distance_q  <= '0;
            prev_q      <= '0;
            velocity_q  <= '0;
            hist_q      <= 1'b0;
            fault_q     <= 1'b0;
            trigger_q   <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            echo_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            cm_q        <= cm_d;
            distance_q  <= distance_d;
            prev_q      <= prev_d;
            velocity_q  <= velocity_d;
            hist_q      <= hist_d;
            fault_q     <= fault_d;
            trigger_q   <= trigger_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            echo_prev_q <= echo_s;
        end
    end

    assign trigger        = trigger_q;
    assign busy           = busy_q;
    assign distance       = distance_q;
    assign velocity       = velocity_q;
    assign velocity_ready = ready_q;
    assign sensor_fault   = fault_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_delivery_velocity_sensor.sv
// Directed bench for delivery_velocity_sensor with shortened timing so a whole
// measurement takes hundreds of clocks instead of milliseconds.
module tb_delivery_velocity_sensor;

    // Echo timeout is raised above the longest echo so a 5000-clock echo can saturate at 400 cm.
    localparam int TRIG = 5;
    localparam int CPC  = 10;
    localparam int TOUT = 6000;
    localparam int MAXC = 400;
    localparam int DW   = 9;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          get_velocity = 1'b0;
    logic          clear = 1'b0;
    logic          echo = 1'b0;
    logic          trigger;
    logic          busy;
    logic [DW-1:0] distance;
    logic [7:0]    velocity;
    logic          velocity_ready;
    logic          sensor_fault;
    logic [2:0]    state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    delivery_velocity_sensor #(
        .TRIGGER_CYCLES (TRIG),
        .CYCLES_PER_CM  (CPC),
        .ECHO_TIMEOUT   (TOUT),
        .MAX_CM         (MAXC),
        .DIST_W         (DW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .get_velocity   (get_velocity),
        .clear          (clear),
        .echo           (echo),
        .trigger        (trigger),
        .busy           (busy),
        .distance       (distance),
        .velocity       (velocity),
        .velocity_ready (velocity_ready),
        .sensor_fault   (sensor_fault),
        .state_dbg      (state_dbg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full measurement; echo_len == 0 means the sensor never answers.
    task automatic run_sample(input int echo_len, output int trig_len,
                              output int ready_cnt, output int ready_lat);
        trig_len  = 0;
        ready_cnt = 0;
        ready_lat = -1;
        get_velocity = 1'b1;
        tick();
        get_velocity = 1'b0;
        while (trigger && trig_len < 100) begin
            trig_len++;
            tick();
        end
        if (echo_len > 0) begin
            repeat (2) tick();
            echo = 1'b1;
            repeat (echo_len) tick();
            echo = 1'b0;
            for (int i = 1; i <= 20; i++) begin
                tick();
                if (velocity_ready) begin
                    ready_cnt++;
                    if (ready_lat < 0) ready_lat = i;
                end
            end
        end else begin
            for (int i = 0; i < TOUT + 2000 && busy; i++) begin
                tick();
                if (velocity_ready) ready_cnt++;
            end
        end
    endtask

    task automatic sample_and_check(input string tag, input int echo_len,
                                    input int exp_dist, input int exp_vel);
        int tl, rc, rl;
        run_sample(echo_len, tl, rc, rl);
        check({tag, "_trig_len"}, tl, TRIG);
        check({tag, "_ready_cnt"}, rc, 1);
        check({tag, "_ready_lat"}, rl, 4);
        check({tag, "_dist"}, int'(distance), exp_dist);
        check({tag, "_vel"}, int'($signed(velocity)), exp_vel);
        check({tag, "_fault"}, int'(sensor_fault), 0);
        check({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int tl, rc, rl;

        repeat (3) tick();
        check("rst_trigger", int'(trigger), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dist", int'(distance), 0);
        check("rst_vel", int'(velocity), 0);
        check("rst_ready", int'(velocity_ready), 0);
        check("rst_fault", int'(sensor_fault), 0);
        check("rst_state", int'(state_dbg), 0);
        reset_n = 1'b1;
        repeat (2) tick();

        sample_and_check("s500", 500, 50, 0);
        sample_and_check("s300", 300, 30, 20);
        sample_and_check("s320", 320, 32, -2);
        sample_and_check("s329", 329, 32, 0);
        sample_and_check("s5000", 5000, 400, -128);
        sample_and_check("s10", 10, 1, 127);

        run_sample(0, tl, rc, rl);
        check("to_trig_len", tl, TRIG);
        check("to_ready_cnt", rc, 0);
        check("to_fault", int'(sensor_fault), 1);
        check("to_dist", int'(distance), 1);
        check("to_vel", int'($signed(velocity)), 127);
        check("to_idle", int'(busy), 0);

        sample_and_check("s200", 200, 20, -19);

        // Abort mid-echo, with a stray start request while busy.
        get_velocity = 1'b1;
        tick();
        get_velocity = 1'b0;
        repeat (TRIG + 2) tick();
        echo = 1'b1;
        repeat (50) tick();
        check("meas_state", int'(state_dbg), 3);
        get_velocity = 1'b1;
        tick();
        get_velocity = 1'b0;
        check("busy_gv_trigger", int'(trigger), 0);
        check("busy_gv_state", int'(state_dbg), 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_busy", int'(busy), 0);
        check("clr_trigger", int'(trigger), 0);
        check("clr_state", int'(state_dbg), 0);
        echo = 1'b0;
        rc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (velocity_ready) rc++;
        end
        check("clr_no_ready", rc, 0);
        check("clr_dist", int'(distance), 20);
        check("clr_vel", int'($signed(velocity)), -19);
        sample_and_check("s150", 150, 15, 5);

        clear = 1'b1;
        get_velocity = 1'b1;
        tick();
        clear = 1'b0;
        get_velocity = 1'b0;
        check("clr_gv_busy", int'(busy), 0);
        check("clr_gv_trigger", int'(trigger), 0);

        get_velocity = 1'b1;
        tick();
        get_velocity = 1'b0;
        check("rst_mid_trig_pre", int'(trigger), 1);
        tick();
        reset_n = 1'b0;
        #1;
        check("arst_trigger", int'(trigger), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_dist", int'(distance), 0);
        check("arst_vel", int'(velocity), 0);
        check("arst_fault", int'(sensor_fault), 0);
        check("arst_state", int'(state_dbg), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();

        sample_and_check("post_rst", 250, 25, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
